collision_msg_schedule: RTL and testbench



---
 rtl/collision_msg_schedule.sv | 121 ++++++++++++
 tb/tb_collision_msg_schedule.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_msg_schedule.sv
// Holds the padded 512-bit base message and streams the SHA-1 schedule W[0..79]
// for each search attempt, with the candidate counter substituted into word 0.
module collision_msg_schedule #(
  parameter int unsigned WORD_SIZE   = 32,
  parameter int unsigned TOTAL_WORDS = 16,
  parameter int unsigned ROUNDS      = 80
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic                 load_valid,
  input  logic [WORD_SIZE-1:0] load_hi,
  input  logic [WORD_SIZE-1:0] load_lo,
  output logic                 load_ready,
  output logic                 block_loaded,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] counter,
  output logic                 busy,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic [WORD_SIZE-1:0] w_data,
  output logic [6:0]           w_index,
  output logic                 w_last,
  output logic                 sched_done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

  logic [1:0]           state;
  logic [2:0]           pair_ptr;
  logic [6:0]           t;
  logic                 loaded;
  logic [WORD_SIZE-1:0] base   [TOTAL_WORDS];
  logic [WORD_SIZE-1:0] window [TOTAL_WORDS];

  logic [3:0]           slot;
  logic [3:0]           idx3;
  logic [3:0]           idx8;
  logic [3:0]           idx14;
  logic [WORD_SIZE-1:0] mixed;
  logic                 handshake;

  // The window is a 16-entry ring: slot t&15 still holds W[t-16] when W[t] is formed.
  always_comb begin
    slot  = t[3:0];
    idx3  = slot - 4'd3;
    idx8  = slot - 4'd8;
    idx14 = slot - 4'd14;
    mixed = window[idx3] ^ window[idx8] ^ window[idx14] ^ window[slot];
    if (t < 7'd16) begin
      w_data = window[slot];
    end else begin
      w_data = {mixed[WORD_SIZE-2:0], mixed[WORD_SIZE-1]};
    end
  end

  assign load_ready   = (state == S_IDLE);
  assign busy         = (state == S_STREAM);
  assign w_valid      = (state == S_STREAM);
  assign sched_done   = (state == S_DONE);
  assign block_loaded = loaded;
  assign w_index      = t;
  assign w_last       = w_valid && (t == LAST_T);
  assign handshake    = w_valid && w_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      pair_ptr <= '0;
      t        <= '0;
      loaded   <= 1'b0;
      for (int unsigned i = 0; i < TOTAL_WORDS; i++) begin
        base[i]   <= '0;
        window[i] <= '0;
      end
    end else if (clk_en) begin
      case (state)
        S_IDLE: begin
          if (load_valid) begin
            base[{pair_ptr, 1'b0}] <= load_hi;
            base[{pair_ptr, 1'b1}] <= load_lo;
            pair_ptr               <= pair_ptr + 3'd1;
            if (pair_ptr == 3'd7) begin
              loaded <= 1'b1;
            end
          end
          if (start && loaded) begin
            window[0] <= counter;
            for (int unsigned i = 1; i < TOTAL_WORDS; i++) begin
              window[i] <= base[i];
            end
            t     <= '0;
            state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (handshake) begin
            if (t >= 7'd16) begin
              window[slot] <= w_data;
            end
            t <= t + 7'd1;
            if (t == LAST_T) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_collision_msg_schedule.sv
// Scoreboard bench for collision_msg_schedule: a reference SHA-1 schedule model
// fills an expectation queue and a negedge monitor checks every presented word.
module tb_collision_msg_schedule;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        load_valid;
  logic [31:0] load_hi;
  logic [31:0] load_lo;
  logic        load_ready;
  logic        block_loaded;
  logic        start;
  logic [31:0] counter;
  logic        busy;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic [6:0]  w_index;
  logic        w_last;
  logic        sched_done;

  always #5 clk = ~clk;

  collision_msg_schedule #(
    .WORD_SIZE  (32),
    .TOTAL_WORDS(16),
    .ROUNDS     (80)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (clk_en),
    .load_valid  (load_valid),
    .load_hi     (load_hi),
    .load_lo     (load_lo),
    .load_ready  (load_ready),
    .block_loaded(block_loaded),
    .start       (start),
    .counter     (counter),
    .busy        (busy),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .w_data      (w_data),
    .w_index     (w_index),
    .w_last      (w_last),
    .sched_done  (sched_done)
  );

  typedef struct packed {
    logic [6:0]  idx;
    logic [31:0] data;
    logic        last;
  } item_t;

  item_t       exp_q[$];
  item_t       mon_e;
  int          tests = 0;
  int          fails = 0;
  int          done_due = 0;
  logic [31:0] model_base [16];
  logic [31:0] exp_w [80];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      if (done_due == 1) begin
        check("sched_done_pulse", 64'(sched_done), 64'd1);
        done_due = 2;
      end else if (done_due == 2) begin
        check("sched_done_single", 64'(sched_done), 64'd0);
        done_due = 0;
      end
      if (w_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got index %0d data %0h, expected no w_valid", w_index, w_data);
        end else begin
          mon_e = exp_q[0];
          check("w_index", 64'(w_index), 64'(mon_e.idx));
          check("w_data", 64'(w_data), 64'(mon_e.data));
          check("w_last", 64'(w_last), 64'(mon_e.last));
          if (w_ready && clk_en) begin
            void'(exp_q.pop_front());
            if (mon_e.last) done_due = 1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pairs(input int first, input int last_excl);
    for (int p = first; p < last_excl; p++) begin
      load_valid = 1'b1;
      load_hi    = model_base[2*p];
      load_lo    = model_base[2*p+1];
      tick();
      load_valid = 1'b0;
    end
  endtask

  task automatic build_model(input logic [31:0] ctr);
    logic [31:0] x;
    exp_w[0] = ctr;
    for (int i = 1; i < 16; i++) exp_w[i] = model_base[i];
    for (int i = 16; i < 80; i++) begin
      x = exp_w[i-3] ^ exp_w[i-8] ^ exp_w[i-14] ^ exp_w[i-16];
      exp_w[i] = {x[30:0], x[31]};
    end
  endtask

  task automatic push_model();
    item_t e;
    for (int i = 0; i < 80; i++) begin
      e.idx  = 7'(i);
      e.data = exp_w[i];
      e.last = (i == 79);
      exp_q.push_back(e);
    end
  endtask

  task automatic issue_start(input logic [31:0] ctr);
    counter = ctr;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy || done_due != 0) && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d words outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  task automatic expect_idle(input string name);
    for (int i = 0; i < 4; i++) begin
      check({name, "_no_valid"}, 64'(w_valid), 64'd0);
      check({name, "_no_busy"}, 64'(busy), 64'd0);
      tick();
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) model_base[i] = 32'h0;
    model_base[0]  = 32'h61626380;
    model_base[15] = 32'h00000018;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int n;
    reset = 1'b1; clk_en = 1'b1; load_valid = 1'b0; load_hi = '0; load_lo = '0;
    start = 1'b0; counter = '0; w_ready = 1'b1;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_w_valid", 64'(w_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_block_loaded", 64'(block_loaded), 64'd0);
    check("rst_sched_done", 64'(sched_done), 64'd0);
    check("rst_w_index", 64'(w_index), 64'd0);
    check("rst_w_data", 64'(w_data), 64'd0);
    check("rst_w_last", 64'(w_last), 64'd0);
    check("rst_load_ready", 64'(load_ready), 64'd1);

    // Start with only seven pairs loaded is ignored
    set_abc();
    load_pairs(0, 7);
    check("partial_block_loaded", 64'(block_loaded), 64'd0);
    issue_start(32'h61626380);
    expect_idle("early_start");
    load_pairs(7, 8);
    check("full_block_loaded", 64'(block_loaded), 64'd1);

    // SHA-1 "abc" run, with a clk_en hold in the middle
    build_model(32'h61626380);
    exp_w[0]  = 32'h61626380;
    exp_w[16] = 32'hC2C4C700;
    push_model();
    issue_start(32'h61626380);
    repeat (20) tick();
    clk_en = 1'b0;
    repeat (3) tick();
    clk_en = 1'b1;
    wait_done("abc");

    // Back-pressure: w_ready alternates 0/1 starting low on the first valid cycle
    build_model(32'h61626380);
    push_model();
    w_ready = 1'b1;
    issue_start(32'h61626380);
    cyc = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      w_ready = ~w_ready;
      @(negedge clk);
      if (w_valid) cyc++;
      @(posedge clk);
      #1;
      n++;
    end
    w_ready = 1'b1;
    check("backpressure_cycles", 64'(cyc), 64'd160);
    wait_done("backpressure");

    // Loads during STREAM are ignored
    build_model(32'h12345678);
    push_model();
    issue_start(32'h12345678);
    repeat (5) tick();
    check("stream_load_ready", 64'(load_ready), 64'd0);
    load_valid = 1'b1; load_hi = 32'hDEADBEEF; load_lo = 32'hCAFEF00D;
    tick(); tick();
    load_valid = 1'b0;
    wait_done("load_in_stream");
    build_model(32'h0BADF00D);
    push_model();
    issue_start(32'h0BADF00D);
    wait_done("after_stream_load");

    // Counter substitution on the "XXXX Keep your FPGA spinning!" block
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) model_base[i] = 32'h0;
    model_base[0] = 32'h58585858; model_base[1] = 32'h204B6565;
    model_base[2] = 32'h7020796F; model_base[3] = 32'h75722046;
    model_base[4] = 32'h50474120; model_base[5] = 32'h7370696E;
    model_base[6] = 32'h6E696E67; model_base[7] = 32'h21800000;
    model_base[15] = 32'h000000E8;
    load_pairs(0, 8);
    build_model(32'h00000000);
    push_model();
    issue_start(32'h00000000);
    wait_done("ctr_zero");
    build_model(32'h0000002A);
    push_model();
    issue_start(32'h0000002A);
    wait_done("ctr_2a");

    // Reset when t = 40 is on the outputs
    build_model(32'h00000055);
    push_model();
    issue_start(32'h00000055);
    n = 0;
    while (!(w_valid && w_index == 7'd39) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL reset_mid_wait: got index %0d, expected to reach 39", w_index);
    end
    @(posedge clk);
    #1;
    check("pre_reset_index", 64'(w_index), 64'd40);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    done_due = 0;
    check("mid_reset_w_valid", 64'(w_valid), 64'd0);
    check("mid_reset_busy", 64'(busy), 64'd0);
    check("mid_reset_block_loaded", 64'(block_loaded), 64'd0);
    issue_start(32'h00000055);
    expect_idle("start_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
